// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - shared types, constants and key-code lookup for the keypad scanner
package teclado_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [6:0] DEL = 7'h7F;
    localparam logic [6:0] CR  = 7'h0D;

    // Legend of the standard 4x4 telephone-style keypad, index = row*4+col
    function automatic logic [6:0] key_ascii(input logic [31:0] idx);
        logic [6:0] code;
        case (idx)
            32'd0:   code = 7'h31;
            32'd1:   code = 7'h32;
            32'd2:   code = 7'h33;
            32'd3:   code = 7'h41;
            32'd4:   code = 7'h34;
            32'd5:   code = 7'h35;
            32'd6:   code = 7'h36;
            32'd7:   code = 7'h42;
            32'd8:   code = 7'h37;
            32'd9:   code = 7'h38;
            32'd10:  code = 7'h39;
            32'd11:  code = 7'h43;
            32'd12:  code = DEL;
            32'd13:  code = 7'h30;
            32'd14:  code = CR;
            32'd15:  code = 7'h44;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/teclado_if.sv
// rtl/teclado_if.sv - key-event output stream with valid/ready handshake
interface teclado_if #(
    parameter int IDX_W = 4
) ();
    logic             key_valid;
    logic             key_ready;
    logic [IDX_W-1:0] key_index;
    logic [6:0]       ascii;

    modport master (output key_valid, output key_index, output ascii, input key_ready);
    modport slave  (input key_valid, input key_index, input ascii, output key_ready);
endinterface

// File: rtl/teclado_fifo.sv
// rtl/teclado_fifo.sv - small key-event buffer with valid/ready pop
module teclado_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_wr;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_valid = !o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_pop   = o_valid && i_ready;
    // A pop frees the head slot in the same cycle, so a full buffer still takes a push
    assign w_wr    = i_push && (!o_full || w_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage array; contents are never observed while empty, so no reset
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/teclado_scan.sv
// rtl/teclado_scan.sv - row-scanning matrix keypad decoder with debounce and event buffer
module teclado_scan
    import teclado_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 16,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_Teclado,
    input  logic            rst,
    output logic [ROWS-1:0] Fila,
    input  logic [COLS-1:0] Columna,
    teclado_if.master       key_bus,
    output logic            key_held,
    output logic            overflow
);
    localparam int IDX_W = $clog2(ROWS*COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE+1);

    logic [DIV_W-1:0] r_div;
    logic [ROW_W-1:0] r_row;
    state_t           r_state, w_next_state;
    logic [ROW_W-1:0] r_lat_row, w_next_row;
    logic [COL_W-1:0] r_lat_col, w_next_col;
    logic [CNT_W-1:0] r_cnt, w_next_cnt, w_cnt_inc;
    logic             r_overflow;
    logic             w_sample, w_hit, w_row_match, w_bit, w_push, w_pop, w_full, w_empty;
    logic [COL_W-1:0] w_col;
    logic [IDX_W-1:0] w_push_index;
    logic [6:0]       w_push_ascii;

    assign w_sample    = (r_div == DIV_W'(SCAN_DIV-1));
    assign Fila        = ROWS'(1) << r_row;
    assign w_hit       = ($countones(Columna) == 1);
    assign w_row_match = w_sample && (r_row == r_lat_row);
    assign w_bit       = Columna[r_lat_col];
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign key_held    = (r_state == ST_HELD) || (r_state == ST_RELEASE);
    assign overflow    = r_overflow;
    assign w_pop       = key_bus.key_valid && key_bus.key_ready;

    // The index of a pushed key always comes from the latched position (or the one being latched)
    assign w_push_index = IDX_W'(32'(w_next_row) * COLS + 32'(w_next_col));
    assign w_push_ascii = key_ascii(32'(w_push_index));

    // Column encoder; only meaningful when exactly one bit is set
    always_comb begin
        w_col = '0;
        for (int i = 0; i < COLS; i++) begin
            if (Columna[i]) w_col = COL_W'(i);
        end
    end

    // Row dwell counter and row rotation
    always_ff @(posedge clk_Teclado or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_row <= '0;
        end else if (w_sample) begin
            r_div <= '0;
            r_row <= (r_row == ROW_W'(ROWS-1)) ? '0 : r_row + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Debounce FSM state registers
    always_ff @(posedge clk_Teclado or posedge rst) begin
        if (rst) begin
            r_state   <= ST_SCAN;
            r_lat_row <= '0;
            r_lat_col <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_lat_row <= w_next_row;
            r_lat_col <= w_next_col;
            r_cnt     <= w_next_cnt;
        end
    end

    // Debounce FSM next state; only samples of the latched row matter once a key is tracked
    always_comb begin
        w_next_state = r_state;
        w_next_row   = r_lat_row;
        w_next_col   = r_lat_col;
        w_next_cnt   = r_cnt;
        w_push       = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (w_sample && w_hit) begin
                    w_next_row = r_row;
                    w_next_col = w_col;
                    w_next_cnt = CNT_W'(1);
                    if (DEBOUNCE == 1) begin
                        w_push       = 1'b1;
                        w_next_state = ST_HELD;
                    end else begin
                        w_next_state = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (w_row_match) begin
                    if (w_hit && (w_col == r_lat_col)) begin
                        w_next_cnt = w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(DEBOUNCE)) begin
                            w_push       = 1'b1;
                            w_next_state = ST_HELD;
                        end
                    end else begin
                        w_next_cnt   = '0;
                        w_next_state = ST_SCAN;
                    end
                end
            end
            ST_HELD: begin
                if (w_row_match && !w_bit) begin
                    if (DEBOUNCE == 1) begin
                        w_next_cnt   = '0;
                        w_next_state = ST_SCAN;
                    end else begin
                        w_next_cnt   = CNT_W'(1);
                        w_next_state = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (w_row_match) begin
                    if (w_bit) begin
                        w_next_cnt   = '0;
                        w_next_state = ST_HELD;
                    end else if (w_cnt_inc == CNT_W'(DEBOUNCE)) begin
                        w_next_cnt   = '0;
                        w_next_state = ST_SCAN;
                    end else begin
                        w_next_cnt = w_cnt_inc;
                    end
                end
            end
            default: w_next_state = ST_SCAN;
        endcase
    end

    // Sticky flag for events lost to a full buffer
    always_ff @(posedge clk_Teclado or posedge rst) begin
        if (rst)                               r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop)   r_overflow <= 1'b1;
    end

    teclado_fifo #(
        .WIDTH (IDX_W + 7),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_Teclado),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({w_push_index, w_push_ascii}),
        .o_valid     (key_bus.key_valid),
        .i_ready     (key_bus.key_ready),
        .o_data      ({key_bus.key_index, key_bus.ascii}),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

endmodule

// File: tb/tb_teclado_scan.sv
// tb/tb_teclado_scan.sv - self-checking bench for the keypad scanner
module tb_teclado_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] Fila;
    logic [3:0] Columna;
    logic       key_held;
    logic       overflow;

    int         key_r = 0;
    logic [3:0] key_mask = 4'b0000;
    logic       key_on = 1'b0;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [10:0] exp_q[$];

    teclado_if #(.IDX_W(4)) kif ();

    teclado_scan #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .clk_Teclado (clk),
        .rst         (rst),
        .Fila        (Fila),
        .Columna     (Columna),
        .key_bus     (kif),
        .key_held    (key_held),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Keypad model: pressed contacts connect the driven row to the masked columns
    assign Columna = (key_on && Fila[key_r]) ? key_mask : 4'b0000;

    function automatic logic [6:0] tb_ascii(input int r, input int c);
        case (r*4 + c)
            0: return 7'h31;  1: return 7'h32;  2: return 7'h33;  3: return 7'h41;
            4: return 7'h34;  5: return 7'h35;  6: return 7'h36;  7: return 7'h42;
            8: return 7'h37;  9: return 7'h38; 10: return 7'h39; 11: return 7'h43;
           12: return 7'h7F; 13: return 7'h30; 14: return 7'h0D; 15: return 7'h44;
            default: return 7'h00;
        endcase
    endfunction

    task automatic expect_key(input int r, input int c);
        logic [3:0] idx;
        idx = 4'(r*4 + c);
        exp_q.push_back({idx, tb_ascii(r, c)});
    endtask

    task automatic press(input int r, input int c);
        key_r    = r;
        key_mask = 4'b0001 << c;
        key_on   = 1'b1;
    endtask

    task automatic monitor();
        logic [10:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && kif.key_valid && kif.key_ready) begin
                checks++;
                pops++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got idx=%0d ascii=%h, none expected", kif.key_index, kif.ascii);
                end else begin
                    e = exp_q.pop_front();
                    if ({kif.key_index, kif.ascii} !== e) begin
                        errors++;
                        $display("FAIL pop_data: got idx=%0d ascii=%h, want idx=%0d ascii=%h",
                                 kif.key_index, kif.ascii, e[10:7], e[6:0]);
                    end
                end
            end
        end
    endtask

    task automatic wait_frame();
        logic [3:0] prev;
        bit found;
        prev  = Fila;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (Fila == 4'b0001 && prev != 4'b0001) found = 1;
            prev = Fila;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_frame: no return to row 0 within 40 cycles, Fila=%b", Fila);
        end
    endtask

    task automatic key_cycle(input int r, input int c);
        wait_frame();
        press(r, c);
        repeat (4) wait_frame();
        key_on = 1'b0;
        repeat (4) wait_frame();
    endtask

    task automatic drain(input int n_exp, input string name);
        int p0;
        p0 = pops;
        kif.key_ready = 1'b1;
        repeat (8) @(negedge clk);
        kif.key_ready = 1'b0;
        checks++;
        if (kif.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty: key_valid=%b, want 0", name, kif.key_valid);
        end
        checks++;
        if (pops - p0 != n_exp) begin
            errors++;
            $display("FAIL %s_pops: got %0d pops, want %0d", name, pops - p0, n_exp);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++; if (Fila !== 4'b0001)       begin errors++; $display("FAIL %s_fila: got %b want 0001", name, Fila); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL %s_valid: got %b want 0", name, kif.key_valid); end
        checks++; if (kif.key_index !== 4'd0) begin errors++; $display("FAIL %s_index: got %0d want 0", name, kif.key_index); end
        checks++; if (kif.ascii !== 7'h00)    begin errors++; $display("FAIL %s_ascii: got %h want 00", name, kif.ascii); end
        checks++; if (key_held !== 1'b0)      begin errors++; $display("FAIL %s_held: got %b want 0", name, key_held); end
        checks++; if (overflow !== 1'b0)      begin errors++; $display("FAIL %s_overflow: got %b want 0", name, overflow); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
    endtask

    task automatic test_single_key();
        wait_frame();
        press(1, 2);
        expect_key(1, 2);
        repeat (39) @(negedge clk);
        checks++;
        if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL single_early: key_valid=%b before 3rd sample, want 0", kif.key_valid); end
        @(negedge clk);
        checks++;
        if (kif.key_valid !== 1'b1) begin errors++; $display("FAIL single_valid: key_valid=%b after 3rd sample, want 1", kif.key_valid); end
        repeat (3) wait_frame();
        checks++;
        if (key_held !== 1'b1) begin errors++; $display("FAIL single_held: key_held=%b, want 1", key_held); end
        key_on = 1'b0;
        repeat (39) @(negedge clk);
        checks++;
        if (key_held !== 1'b1) begin errors++; $display("FAIL single_release_early: key_held=%b, want 1", key_held); end
        @(negedge clk);
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL single_release: key_held=%b, want 0", key_held); end
        drain(1, "single");
    endtask

    task automatic test_bounce();
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int f = 0; f < 5; f++) begin
            wait_frame();
            if (f == 4) begin
                checks++;
                if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL bounce_early: key_valid=%b after 2 hits, want 0", kif.key_valid); end
            end
            press(3, 0);
            key_on = pat[f];
        end
        expect_key(3, 0);
        wait_frame();
        checks++;
        if (kif.key_valid !== 1'b1) begin errors++; $display("FAIL bounce_accept: key_valid=%b after 3rd hit, want 1", kif.key_valid); end
        key_on = 1'b0;
        repeat (4) wait_frame();
        drain(1, "bounce");
    endtask

    task automatic test_ghost();
        wait_frame();
        key_r    = 0;
        key_mask = 4'b0011;
        key_on   = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_frame();
            checks++;
            if (key_held !== 1'b0) begin errors++; $display("FAIL ghost_held: key_held=%b in frame %0d, want 0", key_held, f); end
        end
        key_on = 1'b0;
        checks++;
        if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL ghost_valid: key_valid=%b, want 0", kif.key_valid); end
    endtask

    task automatic test_overflow();
        int kr [5] = '{0, 1, 2, 3, 0};
        int kc [5] = '{0, 1, 2, 3, 3};
        for (int k = 0; k < 5; k++) begin
            if (k < 4) expect_key(kr[k], kc[k]);
            key_cycle(kr[k], kc[k]);
            if (k == 3) begin
                checks++;
                if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: overflow=%b with 4 entries, want 0", overflow); end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: overflow=%b after 5th key, want 1", overflow); end
        drain(4, "ovf");
    endtask

    task automatic test_reset_mid_press();
        wait_frame();
        press(3, 2);
        wait_frame();
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_key(3, 2);
        repeat (47) @(negedge clk);
        checks++;
        if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL rst_redebounce_early: key_valid=%b, want 0", kif.key_valid); end
        @(negedge clk);
        checks++;
        if (kif.key_valid !== 1'b1) begin errors++; $display("FAIL rst_redebounce: key_valid=%b, want 1", kif.key_valid); end
        key_on = 1'b0;
        repeat (4) wait_frame();
        drain(1, "rst");
    endtask

    task automatic test_back_to_back();
        int kr [4] = '{0, 1, 2, 3};
        int kc [4] = '{1, 0, 1, 1};
        for (int k = 0; k < 4; k++) begin
            expect_key(kr[k], kc[k]);
            key_cycle(kr[k], kc[k]);
        end
        wait_frame();
        press(1, 3);
        expect_key(1, 3);
        repeat (39) @(negedge clk);
        kif.key_ready = 1'b1;
        @(negedge clk);
        kif.key_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: overflow=%b, want 0", overflow); end
        checks++;
        if (kif.key_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: key_valid=%b, want 1", kif.key_valid); end
        key_on = 1'b0;
        repeat (4) wait_frame();
        drain(4, "b2b");
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: %0d expected entries never popped", exp_q.size()); end
    endtask

    initial begin
        kif.key_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_key();
        test_bounce();
        test_ghost();
        test_overflow();
        test_reset_mid_press();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/teclado_scan.md
TECLADO_SCAN -- requirements
Module: teclado_scan

Interface
REQ-001 Parameter ROWS, 4, number of matrix rows driven (2..8).
REQ-002 Parameter COLS, 4, number of matrix columns sensed (2..8).
REQ-003 Parameter SCAN_DIV, 16, clock cycles each row is driven before its columns are sampled (>=2).
REQ-004 Parameter DEBOUNCE, 4, consecutive matching samples of one row needed to accept a press or a release (>=1).
REQ-005 Parameter FIFO_DEPTH, 4, key-event buffer entries (power of two, >=2).
REQ-006 clk_Teclado  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 Fila  output  ROWS  one-hot row drive, active-high.
REQ-009 Columna  input  COLS  column sense, active-high, already synchronised externally.
REQ-010 key_valid  output  1  FIFO non-empty.
REQ-011 key_ready  input  1  consumer accepts the head entry.
REQ-012 key_index  output  clog2(ROWS*COLS)  head entry index, row*COLS+col.
REQ-013 ascii  output  7  head entry ASCII code.
REQ-014 key_held  output  1  a debounced key is currently held.
REQ-015 overflow  output  1  sticky: a key event was dropped because the FIFO was full.

Function
REQ-016 A row counter SHALL drive Fila=1<<row, hold each row SCAN_DIV cycles, sample Columna in the last cycle of the dwell, and wrap from ROWS-1 to 0.
REQ-017 A sample SHALL count as a hit only if exactly one Columna bit is set; zero or multiple bits (ghosting) count as no hit.
REQ-018 The FSM SHALL have states SCAN, DEBOUNCE, HELD, RELEASE; scanning continues in every state.
REQ-019 SCAN: on a hit at (r,c), latch r and c, set the counter to 1, go DEBOUNCE.
REQ-020 DEBOUNCE: on each sample of row r, a hit at c increments the counter; on reaching DEBOUNCE, push (index, ascii) and go HELD; any other result returns to SCAN with no push.
REQ-021 HELD: a sample of row r without bit c set SHALL set the counter to 1 and go RELEASE; samples of other rows and other keys are ignored (no rollover).
REQ-022 RELEASE: DEBOUNCE consecutive samples of row r without bit c SHALL return to SCAN; bit c reappearing returns to HELD with no new push.
REQ-023 key_held SHALL be high in HELD and RELEASE.
REQ-024 ASCII map for a 4x4 matrix (row,col): (0,0..3) "1","2","3","A"; (1,x) "4","5","6","B"; (2,x) "7","8","9","C"; (3,0) 0x7F DELETE; (3,1) "0"; (3,2) 0x0D ENTER; (3,3) "D"; any other index maps to 0x00.
REQ-025 The push SHALL be registered: key_valid rises on the cycle after the accepting sample when the FIFO was empty.
REQ-026 Pop SHALL occur when key_valid and key_ready are both high; key_index/ascii then present the next entry on the following cycle.
REQ-027 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-028 A push while full without a pop SHALL be dropped and SHALL set overflow; FIFO contents remain unchanged.
REQ-029 With the FIFO empty, key_index and ascii SHALL be 0.

Reset
REQ-030 rst SHALL immediately force Fila=1 (row 0), state SCAN, counters 0, FIFO empty, key_valid=0, key_index=0, ascii=0, key_held=0, overflow=0.
REQ-031 Reset asserted mid-press SHALL discard the press; after release of reset, a still-held key SHALL be re-debounced from SCAN.

Structure
REQ-032 Package teclado_pkg SHALL hold the FSM state type, the 4x4 ASCII lookup function, and the constants DEL=0x7F and CR=0x0D.
REQ-033 The FIFO SHALL be a sub-module teclado_fifo (parametrised width and depth, valid/ready pop, full/empty flags).

Verification (bench: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=4)
REQ-034 Hold row 1 col 2 for 5 scan frames, then release -> one entry, index 6, ascii 0x36; key_valid rises 1 cycle after the 3rd matching sample; key_held falls after 3 clean samples.
REQ-035 Bounce on row 3 col 0: hit, miss, hit, hit, hit -> exactly one entry, ascii 0x7F, accepted only on the 3rd consecutive hit.
REQ-036 Columna=0b0011 while row 0 is driven -> no entry, key_held stays 0.
REQ-037 key_ready=0, five distinct press/release cycles -> 4 entries in press order, overflow=1, 5th key lost; then drain with key_ready=1 -> 4 pops, key_valid=0.
REQ-038 FIFO full, key_ready=1 on the cycle of a new push -> both occur, count stays 4, overflow stays 0.
REQ-039 rst pulsed while in DEBOUNCE for row 3 col 2 -> all outputs at reset values asynchronously; the key held through reset yields one entry ascii 0x0D after 3 fresh samples.
